// File: rtl/exc_return_ctrl.sv
// Return-from-exception sequencer: owns the supervisor/user mode bit, drains the
// pipeline on RFE, strobes the PC reload from the saved IAR and drops to user mode.
module exc_return_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic        RESET_MODE   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rfe_valid,
    input  logic        exception,
    input  logic [31:0] iar_in,
    output logic        s_u,
    output logic        busy,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        rfe_illegal,
    output logic        rfe_misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        s_u_next;
    logic        illegal_next;
    logic        misalign_next;
    logic [31:0] target_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            s_u          <= RESET_MODE;
            pc_target    <= 32'h0;
            rfe_illegal  <= 1'b0;
            rfe_misalign <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            s_u          <= s_u_next;
            pc_target    <= target_next;
            rfe_illegal  <= illegal_next;
            rfe_misalign <= misalign_next;
        end
    end

    // Exception is the entry event, so it outranks RFE and aborts any sequence.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        s_u_next      = s_u;
        illegal_next  = 1'b0;
        misalign_next = 1'b0;
        target_next   = pc_target;
        case (state)
            IDLE: begin
                if (exception) begin
                    s_u_next = 1'b0;
                end else if (rfe_valid) begin
                    if (s_u) begin
                        illegal_next = 1'b1;
                    end else begin
                        target_next   = {iar_in[31:2], 2'b00};
                        misalign_next = |iar_in[1:0];
                        cnt_next      = CNT_INIT;
                        state_next    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (exception) begin
                    s_u_next   = 1'b0;
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = LOAD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            LOAD: begin
                s_u_next   = !exception;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign flush   = (state != IDLE);
    // A concurrent exception must not let the return address reach the PC.
    assign pc_load = (state == LOAD) && !exception;

endmodule

// File: tb/tb_exc_return_ctrl.sv
// Directed bench for exc_return_ctrl: reset, normal/illegal/aborted RFE,
// exception in LOAD, misaligned return address and reset mid-drain.
module tb_exc_return_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rfe_valid;
    logic        exception;
    logic [31:0] iar_in;
    logic        s_u;
    logic        busy;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        rfe_illegal;
    logic        rfe_misalign;

    int vectors = 0;
    int miscompares = 0;

    exc_return_ctrl #(.DRAIN_CYCLES(3), .RESET_MODE(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .rfe_valid    (rfe_valid),
        .exception    (exception),
        .iar_in       (iar_in),
        .s_u          (s_u),
        .busy         (busy),
        .flush        (flush),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .rfe_illegal  (rfe_illegal),
        .rfe_misalign (rfe_misalign)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rfe, input logic exc, input logic [31:0] iar);
        rfe_valid = rfe;
        exception = exc;
        iar_in    = iar;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("reset_s_u", 32'(s_u), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_flush", 32'(flush), 32'd0);
        checkOutput("reset_pc_load", 32'(pc_load), 32'd0);
        checkOutput("reset_pc_target", pc_target, 32'h0);
        checkOutput("reset_illegal", 32'(rfe_illegal), 32'd0);
        checkOutput("reset_misalign", 32'(rfe_misalign), 32'd0);
        reset = 1'b1;
        tick();

        // Normal RFE: four flush cycles, pc_load on the fourth, then user mode
        applyStimulus(1'b1, 1'b0, 32'h0000_2004);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF);
            checkOutput($sformatf("norm_flush_c%0d", i), 32'(flush), 32'd1);
            checkOutput($sformatf("norm_busy_c%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("norm_pc_load_c%0d", i), 32'(pc_load), (i == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("norm_s_u_c%0d", i), 32'(s_u), 32'd0);
        end
        checkOutput("norm_pc_target", pc_target, 32'h0000_2004);
        checkOutput("norm_misalign", 32'(rfe_misalign), 32'd0);
        tick();
        checkOutput("norm_s_u_after", 32'(s_u), 32'd1);
        checkOutput("norm_busy_after", 32'(busy), 32'd0);
        checkOutput("norm_pc_load_after", 32'(pc_load), 32'd0);

        // Illegal RFE from user mode
        applyStimulus(1'b1, 1'b0, 32'h0000_5554);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("illegal_pulse", 32'(rfe_illegal), 32'd1);
        checkOutput("illegal_busy", 32'(busy), 32'd0);
        checkOutput("illegal_flush", 32'(flush), 32'd0);
        checkOutput("illegal_pc_load", 32'(pc_load), 32'd0);
        checkOutput("illegal_s_u", 32'(s_u), 32'd1);
        checkOutput("illegal_target_held", pc_target, 32'h0000_2004);
        tick();
        checkOutput("illegal_pulse_end", 32'(rfe_illegal), 32'd0);

        // Simultaneous RFE and exception in IDLE: exception wins
        applyStimulus(1'b1, 1'b1, 32'h0000_4444);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("simul_s_u", 32'(s_u), 32'd0);
        checkOutput("simul_busy", 32'(busy), 32'd0);
        checkOutput("simul_illegal", 32'(rfe_illegal), 32'd0);
        checkOutput("simul_target", pc_target, 32'h0000_2004);
        tick();
        checkOutput("simul_busy_next", 32'(busy), 32'd0);

        // Abort on second DRAIN cycle
        applyStimulus(1'b1, 1'b0, 32'h0000_1000);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("abort_in_drain", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_flush", 32'(flush), 32'd0);
        checkOutput("abort_s_u", 32'(s_u), 32'd0);
        checkOutput("abort_target", pc_target, 32'h0000_1000);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("abort_no_load_%0d", i), 32'(pc_load), 32'd0);
            tick();
        end
        checkOutput("abort_s_u_later", 32'(s_u), 32'd0);

        // Exception during LOAD
        applyStimulus(1'b1, 1'b0, 32'h0000_8008);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        checkOutput("eload_pc_load_pre", 32'(pc_load), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h0);
        #1;
        checkOutput("eload_pc_load_forced", 32'(pc_load), 32'd0);
        checkOutput("eload_flush", 32'(flush), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("eload_s_u", 32'(s_u), 32'd0);
        checkOutput("eload_busy", 32'(busy), 32'd0);
        checkOutput("eload_pc_load_after", 32'(pc_load), 32'd0);

        // Misaligned return address, then reset mid-drain
        applyStimulus(1'b1, 1'b0, 32'h0000_3003);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("mis_pulse", 32'(rfe_misalign), 32'd1);
        checkOutput("mis_target", pc_target, 32'h0000_3000);
        checkOutput("mis_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("mis_pulse_end", 32'(rfe_misalign), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_flush", 32'(flush), 32'd0);
        checkOutput("rst_mid_s_u", 32'(s_u), 32'd0);
        checkOutput("rst_mid_target", pc_target, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_mid_no_load", 32'(pc_load), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
